sysu_tri_bus_ctrl: RTL



---
 rtl/sysu_bus_pkg.sv | 12 +
 rtl/sysu_rr_arbiter.sv | 36 +++
 rtl/sysu_tri_bus_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sysu_bus_pkg.sv
// Shared definitions for the tri-state bus controller and its round-robin arbiter.
package sysu_bus_pkg;

  localparam int unsigned SRC_W = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StTurn  = 2'd2
  } bus_state_e;

endpackage

// File: rtl/sysu_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or after last+1, wrapping mod N.
module sysu_rr_arbiter
  import sysu_bus_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]     req,
  input  logic [SRC_W-1:0] last,
  output logic [N-1:0]     pick,
  output logic [SRC_W-1:0] idx
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  int unsigned   cand;
  logic [IW-1:0] cand_idx;
  logic          found;

  always_comb begin
    pick     = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand     = (32'(last) + k) % N;
      cand_idx = IW'(cand);
      if (!found && req[cand_idx]) begin
        found          = 1'b1;
        pick[cand_idx] = 1'b1;
        idx            = SRC_W'(cand);
      end
    end
  end

endmodule

// File: rtl/sysu_tri_bus_ctrl.sv
// Shared tri-state bus owner: round-robin grant, bounded hold, one-cycle turnaround,
// and registered capture of the resolved bus on every non-first drive cycle.
module sysu_tri_bus_ctrl
  import sysu_bus_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned W        = 8,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     oe_n,
  output logic [N-1:0]     gnt,
  input  logic [W-1:0]     bus,
  output logic [W-1:0]     rx_data,
  output logic             rx_valid,
  output logic [SRC_W-1:0] rx_src,
  output logic             busy
);

  localparam int unsigned IW      = (N > 1) ? $clog2(N) : 1;
  localparam logic [7:0]  MaxHold = 8'(MAX_HOLD);

  bus_state_e       state_q, state_d;
  logic [SRC_W-1:0] owner_q, owner_d;
  logic [SRC_W-1:0] last_q, last_d;
  logic [7:0]       hold_q, hold_d;
  logic [N-1:0]     oe_n_q, oe_n_d;
  logic [W-1:0]     rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic [SRC_W-1:0] rx_src_q, rx_src_d;
  logic             busy_q, busy_d;

  logic [N-1:0]     pick;
  logic [SRC_W-1:0] pick_idx;
  logic [IW-1:0]    owner_idx;

  sysu_rr_arbiter #(
    .N(N)
  ) u_arb (
    .req  (req),
    .last (last_q),
    .pick (pick),
    .idx  (pick_idx)
  );

  assign owner_idx = owner_q[IW-1:0];

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    hold_d     = hold_q;
    oe_n_d     = oe_n_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_src_d   = rx_src_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d = StDrive;
          owner_d = pick_idx;
          hold_d  = 8'd1;
          oe_n_d  = ~pick;
        end
      end
      StDrive: begin
        // First drive cycle lets the bus settle; every later one is captured.
        if (hold_q != 8'd1) begin
          rx_valid_d = 1'b1;
          rx_data_d  = bus;
          rx_src_d   = owner_q;
        end
        if (!req[owner_idx] || hold_q == MaxHold) begin
          state_d = StTurn;
          oe_n_d  = '1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      StTurn: begin
        last_d  = owner_q;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        oe_n_d  = '1;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      owner_q    <= '0;
      last_q     <= SRC_W'(N - 1);
      hold_q     <= '0;
      oe_n_q     <= '1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_src_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      hold_q     <= hold_d;
      oe_n_q     <= oe_n_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_src_q   <= rx_src_d;
      busy_q     <= busy_d;
    end
  end

  assign oe_n     = oe_n_q;
  assign gnt      = ~oe_n_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_src   = rx_src_q;
  assign busy     = busy_q;

endmodule
